// File: rtl/qupls_decode_ibuf_pkg.sv
// rtl/qupls_decode_ibuf_pkg.sv - shared types and constants for the decode instruction buffer
package QuplsPkg;

    localparam int PCW_DEFAULT = 32;

    typedef struct packed {
        logic [40:0] payload;
        logic [6:0]  opcode;
    } instruction_t;

    localparam int INSTR_W = $bits(instruction_t);

    // Opcodes that must execute with the pipeline drained (execute-run-complete)
    localparam logic [6:0] OP_SYS   = 7'h07;
    localparam logic [6:0] OP_CSR   = 7'h0F;
    localparam logic [6:0] OP_RTE   = 7'h3F;
    localparam logic [6:0] OP_FENCE = 7'h7F;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } ibuf_state_t;

endpackage

// File: rtl/qupls_decode_ibuf_erc.sv
// rtl/qupls_decode_ibuf_erc.sv - classifies an opcode as ERC (serializing) class
module Qupls_decode_erc
    import QuplsPkg::*;
(
    input  logic [6:0] opcode,
    output logic       erc
);

    always_comb begin
        erc = 1'b0;
        case (opcode)
            OP_SYS, OP_CSR, OP_RTE, OP_FENCE: erc = 1'b1;
            default:                          erc = 1'b0;
        endcase
    end

endmodule

// File: rtl/qupls_decode_ibuf.sv
// rtl/qupls_decode_ibuf.sv - instruction queue ahead of decode with ERC serialization
module qupls_decode_ibuf
    import QuplsPkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PCW   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_W-1:0]        in_instr,
    input  logic [PCW-1:0]            in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [PCW-1:0]            out_pc,
    output logic                      out_erc,
    input  logic                      pipe_empty,
    input  logic                      erc_done,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PCW-1:0]     mem_pc    [DEPTH];

    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count_q;
    ibuf_state_t    state;

    instruction_t   head_instr;
    logic           head_erc;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign count      = count_q;
    assign head_instr = instruction_t'(mem_instr[rd_ptr]);

    Qupls_decode_erc u_erc (
        .opcode (head_instr.opcode),
        .erc    (head_erc)
    );

    // Head fields are forced to zero while the queue is empty so outputs are clean out of reset
    assign out_instr = empty ? '0 : head_instr;
    assign out_pc    = empty ? '0 : mem_pc[rd_ptr];
    assign out_erc   = !empty & head_erc;

    always_comb begin
        out_valid = 1'b0;
        case (state)
            RUN:     out_valid = !empty & !head_erc;
            DRAIN:   out_valid = 1'b0;
            ISSUE:   out_valid = !empty;
            HOLD:    out_valid = 1'b0;
            default: out_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            state   <= RUN;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            // ERC heads wait for older work to leave, issue alone, then block younger ones until commit
            case (state)
                RUN:     if (!empty && head_erc) state <= DRAIN;
                DRAIN:   if (pipe_empty)         state <= ISSUE;
                ISSUE:   if (pop)                state <= HOLD;
                HOLD:    if (erc_done)           state <= RUN;
                default:                         state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_qupls_decode_ibuf.sv
// tb/tb_qupls_decode_ibuf.sv - scoreboard testbench for qupls_decode_ibuf
module tb_qupls_decode_ibuf;

    localparam int DEPTH = 8;
    localparam int PCW   = 32;
    localparam int IW    = 48;
    localparam logic [6:0] OP_ADD = 7'h04;
    localparam logic [6:0] OP_CSR = 7'h0F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IW-1:0]   in_instr = '0;
    logic [PCW-1:0]  in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IW-1:0]   out_instr;
    logic [PCW-1:0]  out_pc;
    logic            out_erc;
    logic            pipe_empty = 1'b0;
    logic            erc_done = 1'b0;
    logic [3:0]      count;

    typedef struct {
        logic [IW-1:0]  instr;
        logic [PCW-1:0] pc;
        logic           erc;
    } exp_t;

    exp_t sb[$];
    logic cur_erc = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   n_popped = 0;

    always #5 clk = ~clk;

    qupls_decode_ibuf #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_erc    (out_erc),
        .pipe_empty (pipe_empty),
        .erc_done   (erc_done),
        .count      (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [6:0] op, input logic [31:0] pc, input logic erc);
        in_valid = 1'b1;
        in_instr = {9'd0, pc, op};
        in_pc    = pc;
        cur_erc  = erc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Sample at negedge, score handshakes, then advance one clock
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_popped++;
                if (sb.size() == 0) begin
                    check("unexpected_pop", {32'd0, out_pc}, 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("out_instr", {16'd0, out_instr}, {16'd0, e.instr});
                    check("out_pc", {32'd0, out_pc}, {32'd0, e.pc});
                    check("out_erc", {63'd0, out_erc}, {63'd0, e.erc});
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{instr: in_instr, pc: in_pc, erc: cur_erc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int  k;
        logic seen;

        // Reset
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        check("rst_count", 64'(count), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_instr", 64'(out_instr), 0);
        check("rst_out_pc", 64'(out_pc), 0);
        check("rst_out_erc", 64'(out_erc), 0);

        // Three plain instructions streamed through
        out_ready = 1'b1;
        present(OP_ADD, 32'h100, 1'b0);
        step();
        check("first_valid_latency", 64'(out_valid), 1);
        check("first_pc", 64'(out_pc), 64'h100);
        present(OP_ADD, 32'h104, 1'b0);
        step();
        present(OP_ADD, 32'h108, 1'b0);
        step();
        idle();
        steps(3);
        check("stream_count", 64'(count), 0);
        check("stream_popped", 64'(n_popped), 3);

        // Fill to full, blocked ninth, then pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            present(OP_ADD, 32'h300 + 32'(4 * i), 1'b0);
            step();
        end
        check("full_count", 64'(count), 8);
        check("full_in_ready", 64'(in_ready), 0);
        present(OP_ADD, 32'h320, 1'b0);
        step();
        check("blocked_count", 64'(count), 8);
        idle();
        out_ready = 1'b1;
        step();
        check("pop_one_count", 64'(count), 7);
        present(OP_ADD, 32'h320, 1'b0);
        step();
        check("push_pop_count", 64'(count), 7);
        out_ready = 1'b0;
        present(OP_ADD, 32'h324, 1'b0);
        step();
        check("refill_count", 64'(count), 8);
        idle();
        out_ready = 1'b1;
        steps(10);
        check("wrap_drain_count", 64'(count), 0);
        check("wrap_sb_empty", 64'(sb.size()), 0);

        // ERC serialization
        pipe_empty = 1'b0;
        present(OP_CSR, 32'h200, 1'b1);
        step();
        check("erc_not_valid_run", 64'(out_valid), 0);
        present(OP_ADD, 32'h204, 1'b0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("drain_out_valid", 64'(out_valid), 0);
            step();
        end
        check("drain_count", 64'(count), 2);
        pipe_empty = 1'b1;
        step();
        check("issue_valid", 64'(out_valid), 1);
        check("issue_erc", 64'(out_erc), 1);
        check("issue_pc", 64'(out_pc), 64'h200);
        step();
        check("hold_valid", 64'(out_valid), 0);
        present(OP_ADD, 32'h208, 1'b0);
        step();
        idle();
        check("hold_push_count", 64'(count), 2);
        steps(2);
        check("hold_still_blocked", 64'(out_valid), 0);
        erc_done = 1'b1;
        step();
        erc_done = 1'b0;
        check("after_done_valid", 64'(out_valid), 1);
        check("after_done_pc", 64'(out_pc), 64'h204);
        steps(3);
        check("erc_count_zero", 64'(count), 0);

        // Flush with pending push
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            present(OP_ADD, 32'h400 + 32'(4 * i), 1'b0);
            step();
        end
        check("pre_flush_count", 64'(count), 5);
        present(OP_ADD, 32'h500, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("flush_count", 64'(count), 0);
        check("flush_out_valid", 64'(out_valid), 0);
        check("flush_in_ready", 64'(in_ready), 1);
        out_ready = 1'b1;
        present(OP_ADD, 32'h600, 1'b0);
        step();
        idle();
        check("post_flush_pc", 64'(out_pc), 64'h600);
        step();

        // Flush while holding after an ERC
        present(OP_CSR, 32'h700, 1'b1);
        step();
        idle();
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            if (out_valid) seen = 1'b1;
            else step();
            k++;
        end
        check("erc_issue_timeout", 64'(seen), 1);
        step();
        check("hold2_valid", 64'(out_valid), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("hold_flush_count", 64'(count), 0);
        present(OP_ADD, 32'h704, 1'b0);
        step();
        idle();
        check("hold_flush_issue", 64'(out_valid), 1);
        check("hold_flush_pc", 64'(out_pc), 64'h704);
        step();

        // Reset while draining
        pipe_empty = 1'b0;
        present(OP_CSR, 32'h800, 1'b1);
        step();
        for (int i = 1; i < 4; i++) begin
            present(OP_ADD, 32'h800 + 32'(4 * i), 1'b0);
            step();
        end
        idle();
        check("pre_rst_count", 64'(count), 4);
        check("pre_rst_valid", 64'(out_valid), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_count", 64'(count), 0);
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_in_ready", 64'(in_ready), 1);
        present(OP_ADD, 32'h900, 1'b0);
        step();
        idle();
        check("mid_rst_run_state", 64'(out_valid), 1);
        check("mid_rst_pc", 64'(out_pc), 64'h900);
        steps(2);

        check("final_sb_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
